// File: rtl/bicubic_ycoord_gen.sv
// Vertical coordinate generator for the bicubic scaler. It walks a signed Q.8
// accumulator through the source rows and emits one clamped row/phase/tap set per output line.
module bicubic_ycoord_gen #(
    parameter int ROW_W  = 12,
    parameter int FRAC_W = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    frame_start,
    input  logic [ROW_W-1:0]        src_height,
    input  logic [ROW_W-1:0]        dst_height,
    input  logic [ROW_W+FRAC_W-1:0] step,
    input  logic                    coord_ready,
    output logic                    coord_valid,
    output logic [ROW_W-1:0]        src_row,
    output logic [FRAC_W:0]         yBlend,
    output logic [FRAC_W:0]         coeffOne,
    output logic [FRAC_W:0]         coeffHalf,
    output logic [ROW_W-1:0]        tap0,
    output logic [ROW_W-1:0]        tap1,
    output logic [ROW_W-1:0]        tap2,
    output logic [ROW_W-1:0]        tap3,
    output logic                    line_last,
    output logic                    busy,
    output logic                    frame_done
);

    localparam int ACC_W = ROW_W + FRAC_W + 1;
    localparam logic signed [ACC_W-1:0] HALF_PIX = ACC_W'(1 << (FRAC_W - 1));

    typedef enum logic [1:0] {IDLE, INIT, CALC, VALID} state_t;

    state_t                    state, state_next;
    logic signed [ACC_W-1:0]   acc;
    logic [ROW_W-1:0]          src_h_q, dst_h_q, line_cnt, last_row;
    logic [ROW_W+FRAC_W-1:0]   step_q;
    logic                      accept;
    logic [ROW_W-1:0]          calc_row;
    logic [FRAC_W-1:0]         calc_frac;
    logic [ROW_W:0]            row_p1, row_p2;

    assign coeffOne    = (FRAC_W+1)'(1) << FRAC_W;
    assign coeffHalf   = (FRAC_W+1)'(1) << (FRAC_W - 1);
    assign coord_valid = (state == VALID);
    assign busy        = (state != IDLE);
    assign accept      = coord_valid && coord_ready;
    assign last_row    = src_h_q - ROW_W'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    // A new frame_start wins over everything, including an accept in the same cycle.
    always_comb begin
        state_next = state;
        if (frame_start) begin
            state_next = INIT;
        end else begin
            unique case (state)
                IDLE:    state_next = IDLE;
                INIT:    state_next = (dst_height == '0) ? IDLE : CALC;
                CALC:    state_next = VALID;
                VALID:   if (accept) state_next = line_last ? IDLE : CALC;
                default: state_next = IDLE;
            endcase
        end
    end

    // Row/phase from the accumulator: negative positions pin to row 0, overshoot pins to the last row.
    always_comb begin
        calc_row  = '0;
        calc_frac = '0;
        if (!acc[ACC_W-1]) begin
            calc_row  = acc[ACC_W-2:FRAC_W];
            calc_frac = acc[FRAC_W-1:0];
        end
        if (calc_row > last_row) begin
            calc_row  = last_row;
            calc_frac = '0;
        end
        row_p1 = {1'b0, calc_row} + (ROW_W+1)'(1);
        row_p2 = {1'b0, calc_row} + (ROW_W+1)'(2);
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            src_h_q    <= '0;
            dst_h_q    <= '0;
            step_q     <= '0;
            acc        <= '0;
            line_cnt   <= '0;
            src_row    <= '0;
            yBlend     <= '0;
            tap0       <= '0;
            tap1       <= '0;
            tap2       <= '0;
            tap3       <= '0;
            line_last  <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= (state != IDLE) && (state_next == IDLE);
            if (state == INIT) begin
                src_h_q  <= src_height;
                dst_h_q  <= dst_height;
                step_q   <= step;
                acc      <= $signed({2'b00, step[ROW_W+FRAC_W-1:1]}) - HALF_PIX;
                line_cnt <= '0;
            end
            if (state == CALC && state_next == VALID) begin
                src_row   <= calc_row;
                yBlend    <= {1'b0, calc_frac};
                tap0      <= (calc_row == '0) ? '0 : calc_row - ROW_W'(1);
                tap1      <= calc_row;
                tap2      <= (row_p1 > {1'b0, last_row}) ? last_row : row_p1[ROW_W-1:0];
                tap3      <= (row_p2 > {1'b0, last_row}) ? last_row : row_p2[ROW_W-1:0];
                line_last <= (line_cnt == dst_h_q - ROW_W'(1));
            end
            if (state == VALID && state_next == CALC) begin
                acc      <= acc + $signed({1'b0, step_q});
                line_cnt <= line_cnt + ROW_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_bicubic_ycoord_gen.sv
// Self-checking bench for bicubic_ycoord_gen: a per-line arithmetic model checked every valid
// cycle, plus hand-computed tables from the scaling examples.
module tb_bicubic_ycoord_gen;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        frame_start = 1'b0;
    logic [11:0] src_height = '0;
    logic [11:0] dst_height = '0;
    logic [19:0] step = '0;
    logic        coord_ready = 1'b0;
    logic        coord_valid;
    logic [11:0] src_row;
    logic [8:0]  y_blend, coeff_one, coeff_half;
    logic [11:0] tap0, tap1, tap2, tap3;
    logic        line_last, busy, frame_done;

    bicubic_ycoord_gen dut (
        .clk(clk), .rst_n(rst_n), .frame_start(frame_start),
        .src_height(src_height), .dst_height(dst_height), .step(step),
        .coord_ready(coord_ready), .coord_valid(coord_valid), .src_row(src_row),
        .yBlend(y_blend), .coeffOne(coeff_one), .coeffHalf(coeff_half),
        .tap0(tap0), .tap1(tap1), .tap2(tap2), .tap3(tap3),
        .line_last(line_last), .busy(busy), .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    typedef struct {
        int row;
        int bl;
        int t[4];
        int last;
    } coord_t;

    int     n_tests = 0;
    int     n_fail = 0;
    int     m_src, m_dst, m_step, m_line;
    int     done_cnt = 0, done_base = 0, acc_cnt = 0, valid_cycles = 0;
    coord_t log_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Source position for output line n, centre aligned, in plain integer arithmetic.
    function automatic coord_t model(input int n, input int src, input int stp);
        coord_t c;
        int a = stp / 2 - 128 + n * stp;
        if (a < 0) begin c.row = 0; c.bl = 0; end
        else       begin c.row = a / 256; c.bl = a % 256; end
        if (c.row > src - 1) begin c.row = src - 1; c.bl = 0; end
        for (int k = 0; k < 4; k++) begin
            int t = c.row - 1 + k;
            if (t < 0) t = 0;
            if (t > src - 1) t = src - 1;
            c.t[k] = t;
        end
        c.last = 0;
        return c;
    endfunction

    // Compare process: every valid cycle against the model, bubble and frame_done after accepts.
    initial begin
        bit prev_acc = 0, prev_last = 0;
        coord_t e;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prev_acc = 0;
                prev_last = 0;
            end else begin
                if (prev_acc && !prev_last) check("bubble_after_accept", coord_valid, 0);
                if (prev_acc && prev_last)  check("frame_done_after_last", frame_done, 1);
                if (frame_done) done_cnt++;
                prev_acc = 0;
                if (coord_valid && !frame_start) begin
                    valid_cycles++;
                    e = model(m_line, m_src, m_step);
                    e.last = (m_line == m_dst - 1);
                    check("line_in_range", m_line < m_dst, 1);
                    check("src_row", src_row, e.row);
                    check("yBlend", y_blend, e.bl);
                    check("tap0", tap0, e.t[0]);
                    check("tap1", tap1, e.t[1]);
                    check("tap2", tap2, e.t[2]);
                    check("tap3", tap3, e.t[3]);
                    check("line_last", line_last, e.last);
                    check("busy_valid", busy, 1);
                    if (coord_ready) begin
                        e.row = src_row; e.bl = y_blend; e.last = line_last;
                        e.t[0] = tap0; e.t[1] = tap1; e.t[2] = tap2; e.t[3] = tap3;
                        log_q.push_back(e);
                        acc_cnt++;
                        prev_acc = 1;
                        prev_last = (m_line == m_dst - 1);
                        m_line++;
                    end
                end
            end
        end
    end

    task automatic start_frame(input int src, input int dst, input int stp);
        @(posedge clk); #1;
        src_height = 12'(src); dst_height = 12'(dst); step = 20'(stp);
        m_src = src; m_dst = dst; m_step = stp; m_line = 0;
        log_q.delete(); acc_cnt = 0; done_base = done_cnt;
        frame_start = 1'b1;
        @(posedge clk); #1;
        frame_start = 1'b0;
    endtask

    task automatic wait_frame(input string name, input int exp_lines);
        for (int i = 0; i < 200; i++) begin
            if (done_cnt > done_base) break;
            @(posedge clk); #1;
        end
        check({name, "_done_seen"}, done_cnt > done_base, 1);
        repeat (4) @(posedge clk);
        #1;
        check({name, "_done_once"}, done_cnt - done_base, 1);
        check({name, "_accepts"}, acc_cnt, exp_lines);
        check({name, "_idle"}, busy, 0);
    endtask

    task automatic wait_line(input int n);
        for (int i = 0; i < 100; i++) begin
            if (log_q.size() == n && coord_valid) break;
            @(posedge clk); #1;
        end
        check("wait_line_reached", log_q.size() == n && coord_valid, 1);
    endtask

    task automatic check_reset_vals(input string name);
        check({name, "_valid"}, coord_valid, 0);
        check({name, "_busy"}, busy, 0);
        check({name, "_done"}, frame_done, 0);
        check({name, "_last"}, line_last, 0);
        check({name, "_row"}, src_row, 0);
        check({name, "_blend"}, y_blend, 0);
        check({name, "_taps"}, {tap0, tap1, tap2, tap3}, 0);
    endtask

    int up_row[8] = '{0, 0, 0, 1, 1, 2, 2, 3};
    int up_bl[8]  = '{0, 64, 192, 64, 192, 64, 192, 64};
    int dn_row[4] = '{0, 2, 4, 6};

    initial begin
        logic [79:0] snap;
        int base_done, base_valid;

        // Reset state and constants
        #1;
        check_reset_vals("reset");
        check("coeffOne", coeff_one, 256);
        check("coeffHalf", coeff_half, 128);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        coord_ready = 1'b1;

        // 2x upscale, with latency pinned
        start_frame(4, 8, 128);
        check("lat_e0_busy", busy, 1);
        check("lat_e0_valid", coord_valid, 0);
        @(posedge clk); #1;
        check("lat_e1_valid", coord_valid, 0);
        @(posedge clk); #1;
        check("lat_e2_valid", coord_valid, 1);
        wait_frame("up", 8);
        check("up_lines", log_q.size(), 8);
        for (int i = 0; i < 8; i++) begin
            if (i < log_q.size()) begin
                check("up_tbl_row", log_q[i].row, up_row[i]);
                check("up_tbl_blend", log_q[i].bl, up_bl[i]);
            end
        end
        if (log_q.size() == 8) begin
            check("up_first_taps", {log_q[0].t[0], log_q[0].t[1], log_q[0].t[2], log_q[0].t[3]},
                  {32'd0, 32'd0, 32'd1, 32'd2});
            check("up_last_taps", {log_q[7].t[0], log_q[7].t[1], log_q[7].t[2], log_q[7].t[3]},
                  {32'd2, 32'd3, 32'd3, 32'd3});
        end

        // 1:1
        start_frame(5, 5, 256);
        wait_frame("one", 5);
        for (int i = 0; i < 5; i++) begin
            if (i < log_q.size()) begin
                check("one_row", log_q[i].row, i);
                check("one_blend", log_q[i].bl, 0);
                check("one_last", log_q[i].last, (i == 4));
            end
        end

        // 2x downscale
        start_frame(8, 4, 512);
        wait_frame("down", 4);
        for (int i = 0; i < 4; i++) begin
            if (i < log_q.size()) begin
                check("down_row", log_q[i].row, dn_row[i]);
                check("down_blend", log_q[i].bl, 128);
            end
        end
        if (log_q.size() == 4)
            check("down_last_taps", {log_q[3].t[0], log_q[3].t[1], log_q[3].t[2], log_q[3].t[3]},
                  {32'd5, 32'd6, 32'd7, 32'd7});

        // Backpressure on line 2
        start_frame(4, 8, 128);
        wait_line(2);
        coord_ready = 1'b0;
        snap = {src_row, 3'b0, y_blend, tap0, tap1, tap2, tap3, line_last, coord_valid};
        repeat (5) begin
            @(posedge clk); #1;
            check("bp_stable", {src_row, 3'b0, y_blend, tap0, tap1, tap2, tap3, line_last, coord_valid} == snap, 1);
        end
        coord_ready = 1'b1;
        wait_frame("bp", 8);
        for (int i = 0; i < 8; i++)
            if (i < log_q.size()) check("bp_row", log_q[i].row, up_row[i]);

        // Abort during VALID of line 3
        start_frame(4, 8, 128);
        wait_line(3);
        frame_start = 1'b1;
        m_line = 0; log_q.delete(); acc_cnt = 0; done_base = done_cnt;
        @(posedge clk); #1;
        frame_start = 1'b0;
        check("abort_valid_drop", coord_valid, 0);
        check("abort_busy", busy, 1);
        @(posedge clk); #1;
        check("abort_calc_valid", coord_valid, 0);
        @(posedge clk); #1;
        check("abort_restart_valid", coord_valid, 1);
        check("abort_restart_row", src_row, 0);
        check("abort_restart_blend", y_blend, 0);
        wait_frame("abort", 8);

        // dst_height = 0
        base_valid = valid_cycles;
        start_frame(4, 0, 128);
        @(posedge clk); #1;
        check("dst0_done", frame_done, 1);
        check("dst0_busy", busy, 0);
        @(posedge clk); #1;
        check("dst0_done_pulse", frame_done, 0);
        check("dst0_no_valid", valid_cycles - base_valid, 0);

        // Reset during VALID
        start_frame(5, 5, 256);
        wait_line(1);
        base_done = done_cnt;
        rst_n = 1'b0;
        #1;
        check_reset_vals("mid_reset");
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("post_reset_idle", busy, 0);
        check("post_reset_no_done", done_cnt - base_done, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
